// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: round-robin, burst-capped arbiter sharing one single-port RAM between a writer and a reader.
// Optional wait-cycle statistics outputs are enabled by defining RAM_ARB_STATS_EN.
module ram_access_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              wr_req_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_gnt_o,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rd_gnt_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  output logic              ram_wren_o,
  output logic              ram_rden_o,
  input  logic [DATA_W-1:0] ram_q_i
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [15:0]       wr_wait_cnt_o,
  output logic [15:0]       rd_wait_cnt_o
`endif
);
  localparam int CW = $clog2(MAX_BURST) + 1;
  typedef enum logic [1:0] {IDLE, GNT_WR, GNT_RD} state_t;
  state_t          r_state, w_nxt;
  logic            r_wr_gnt, r_rd_gnt, r_last_rd, r_rd_valid;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_inc;
  logic            w_cap, w_wr_beat, w_rd_beat;
  assign w_wr_beat  = wr_req_i && r_wr_gnt;
  assign w_rd_beat  = rd_req_i && r_rd_gnt;
  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_cap      = w_cnt_inc == CW'(MAX_BURST);
  assign wr_gnt_o   = r_wr_gnt;
  assign rd_gnt_o   = r_rd_gnt;
  assign rd_valid_o = r_rd_valid;
  assign rd_data_o  = ram_q_i;
  // Next owner: a tie from IDLE goes to the side not served last; an owner yields when it stops or hits the cap while the other waits
  always_comb begin
    w_nxt = IDLE;
    case (r_state)
      IDLE:    w_nxt = (wr_req_i && (!rd_req_i || r_last_rd)) ? GNT_WR : rd_req_i ? GNT_RD : IDLE;
      GNT_WR:  w_nxt = ((!wr_req_i || w_cap) && rd_req_i) ? GNT_RD : !wr_req_i ? IDLE : GNT_WR;
      GNT_RD:  w_nxt = ((!rd_req_i || w_cap) && wr_req_i) ? GNT_WR : !rd_req_i ? IDLE : GNT_RD;
      default: w_nxt = IDLE;
    endcase
  end
  // State, registered grants, burst counter (cleared on entry and at the cap), last-served side and read-valid strobe
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state    <= IDLE;
      r_wr_gnt   <= 1'b0;
      r_rd_gnt   <= 1'b0;
      r_last_rd  <= 1'b1;
      r_cnt      <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_wr_gnt   <= w_nxt == GNT_WR;
      r_rd_gnt   <= w_nxt == GNT_RD;
      r_rd_valid <= w_rd_beat;
      r_cnt      <= (w_nxt != r_state || w_cap) ? '0 : (w_wr_beat || w_rd_beat) ? w_cnt_inc : r_cnt;
      if (w_nxt != r_state && w_nxt != IDLE) r_last_rd <= w_nxt == GNT_RD;
    end
  end
  // RAM port mux driven straight from the beat so the granted requester's first beat lands without delay
  always_comb begin
    ram_wren_o = w_wr_beat;
    ram_rden_o = w_rd_beat;
    ram_addr_o = w_wr_beat ? wr_addr_i : w_rd_beat ? rd_addr_i : '0;
    ram_data_o = w_wr_beat ? wr_data_i : '0;
  end
`ifdef RAM_ARB_STATS_EN
  logic [15:0] r_wr_wait, r_rd_wait;
  assign wr_wait_cnt_o = r_wr_wait;
  assign rd_wait_cnt_o = r_rd_wait;
  // Saturating count of cycles each side spends requesting without a grant
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wr_wait <= '0;
      r_rd_wait <= '0;
    end else begin
      if (wr_req_i && !r_wr_gnt && r_wr_wait != 16'hFFFF) r_wr_wait <= r_wr_wait + 16'd1;
      if (rd_req_i && !r_rd_gnt && r_rd_wait != 16'hFFFF) r_rd_wait <= r_rd_wait + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb_ram_access_arbiter: randomized and directed checks of ram_access_arbiter against an ownership-level reference model.
module tb_ram_access_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int MB = 4;
  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          wr_req_i = 1'b0, rd_req_i = 1'b0;
  logic [AW-1:0] wr_addr_i = '0, rd_addr_i = '0;
  logic [DW-1:0] wr_data_i = '0;
  logic          wr_gnt_o, rd_gnt_o, rd_valid_o, ram_wren_o, ram_rden_o;
  logic [DW-1:0] rd_data_o, ram_data_o;
  logic [AW-1:0] ram_addr_o;
  logic [DW-1:0] ram_q = '0;
`ifdef RAM_ARB_STATS_EN
  logic [15:0]   wr_wait_cnt_o, rd_wait_cnt_o;
`endif
  bit   [DW-1:0] ram [1024];
  bit   [DW-1:0] mm [1024];
  bit            pre_en = 1'b0;
  logic [AW-1:0] pre_a = '0;
  logic [DW-1:0] pre_d = '0;
  logic [AW-1:0] wa, ra;
  logic [DW-1:0] wd;
  int            m_own, m_run, m_last, ew, er, lb;
  bit            m_pend;
  logic [DW-1:0] m_pdata;
  int            checks = 0, errors = 0;

  ram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_gnt_o(wr_gnt_o),
    .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_gnt_o(rd_gnt_o),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
    .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .ram_wren_o(ram_wren_o), .ram_rden_o(ram_rden_o),
    .ram_q_i(ram_q)
`ifdef RAM_ARB_STATS_EN
    , .wr_wait_cnt_o(wr_wait_cnt_o), .rd_wait_cnt_o(rd_wait_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_en) ram[pre_a] <= pre_d;
    else begin
      if (ram_wren_o) ram[ram_addr_o] <= ram_data_o;
      if (ram_rden_o) ram_q <= ram[ram_addr_o];
    end
  end

  task automatic model_reset();
    m_own = -1; m_run = 0; m_last = 1; m_pend = 0; ew = 0; er = 0; lb = 0;
  endtask

  // one clock: drive requests, compare at negedge with the model, then advance the model
  task automatic cycle(input bit w, input bit r);
    bit eg_w, eg_r, wb, rb;
    bit req[2];
    logic [AW-1:0] ea;
    int prev, o;
    wr_req_i = w; rd_req_i = r; wr_addr_i = wa; wr_data_i = wd; rd_addr_i = ra;
    eg_w = m_own == 0; eg_r = m_own == 1;
    wb = w && eg_w; rb = r && eg_r;
    ea = wb ? wa : (rb ? ra : '0);
    @(negedge clk);
    checks++; if ({wr_gnt_o, rd_gnt_o} !== {eg_w, eg_r}) begin errors++; $display("FAIL grants got %b%b exp %b%b t=%0t", wr_gnt_o, rd_gnt_o, eg_w, eg_r, $time); end
    checks++; if ({ram_wren_o, ram_rden_o} !== {wb, rb}) begin errors++; $display("FAIL enables got %b%b exp %b%b t=%0t", ram_wren_o, ram_rden_o, wb, rb, $time); end
    checks++; if (ram_addr_o !== ea) begin errors++; $display("FAIL ram_addr got %h exp %h t=%0t", ram_addr_o, ea, $time); end
    checks++; if (ram_data_o !== (wb ? wd : '0)) begin errors++; $display("FAIL ram_data got %h exp %h t=%0t", ram_data_o, wb ? wd : '0, $time); end
    checks++; if (rd_valid_o !== m_pend) begin errors++; $display("FAIL rd_valid got %b exp %b t=%0t", rd_valid_o, m_pend, $time); end
    if (m_pend) begin
      checks++; if (rd_data_o !== m_pdata) begin errors++; $display("FAIL rd_data got %h exp %h t=%0t", rd_data_o, m_pdata, $time); end
    end
`ifdef RAM_ARB_STATS_EN
    checks++; if (wr_wait_cnt_o !== 16'(ew) || rd_wait_cnt_o !== 16'(er)) begin errors++; $display("FAIL wait_cnt got %0d/%0d exp %0d/%0d", wr_wait_cnt_o, rd_wait_cnt_o, ew, er); end
`endif
    @(posedge clk);
    m_pend = rb;
    if (rb) m_pdata = mm[ra];
    if (wb) mm[wa] = wd;
    if (w && !eg_w && ew < 65535) ew++;
    if (r && !eg_r && er < 65535) er++;
    req[0] = w; req[1] = r;
    prev = m_own;
    if (m_own == -1) begin
      if (w || r) m_own = (w && r) ? 1 - m_last : (w ? 0 : 1);
    end else begin
      o = 1 - m_own;
      if (!req[m_own]) m_own = req[o] ? o : -1;
      else begin
        m_run++;
        if (m_run == MB) begin
          m_run = 0;
          if (req[o]) m_own = o;
        end
      end
    end
    if (m_own != prev && m_own != -1) begin m_last = m_own; m_run = 0; end
    lb = wb ? 1 : (rb ? 2 : 0);
    if (wb) begin wa++; wd++; end
    if (rb) ra++;
    #1;
  endtask

  task automatic do_reset();
    wr_req_i = 0; rd_req_i = 0; reset_i = 1;
    @(posedge clk); #1;
    reset_i = 0;
    model_reset();
  endtask

  task automatic test_reset();
    wr_req_i = 0; rd_req_i = 0; reset_i = 1;
    @(negedge clk);
    checks++; if ({wr_gnt_o, rd_gnt_o, ram_wren_o, ram_rden_o, rd_valid_o} !== 5'b0) begin errors++; $display("FAIL reset_outputs got %b exp 00000", {wr_gnt_o, rd_gnt_o, ram_wren_o, ram_rden_o, rd_valid_o}); end
    checks++; if (ram_addr_o !== '0 || ram_data_o !== '0) begin errors++; $display("FAIL reset_bus got %h/%h exp 0/0", ram_addr_o, ram_data_o); end
    @(posedge clk); #1;
    reset_i = 0;
    model_reset();
    wa = 0; ra = 0; wd = 0;
    repeat (5) cycle(0, 0);
    checks++; if ({wr_gnt_o, rd_gnt_o, rd_valid_o} !== 3'b0) begin errors++; $display("FAIL idle_after_reset got %b exp 000", {wr_gnt_o, rd_gnt_o, rd_valid_o}); end
  endtask

  task automatic test_writer_alone();
    int n = 0, beats = 0, first = -1;
    do_reset();
    wa = 0; wd = 32'hA0;
    while (beats < 4 && n < 12) begin
      cycle(1, 0);
      if (lb == 1) begin if (first < 0) first = n; beats++; end
      n++;
    end
    checks++; if (beats != 4 || first != 1) begin errors++; $display("FAIL writer_alone got beats=%0d first=%0d exp beats=4 first=1", beats, first); end
    repeat (2) cycle(0, 0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (ram[i] !== 32'hA0 + i) begin errors++; $display("FAIL writer_data[%0d] got %h exp %h", i, ram[i], 32'hA0 + i); end
    end
  endtask

  task automatic test_read_latency();
    int n = 0;
    do_reset();
    pre_en = 1; pre_a = 5; pre_d = 32'hDEADBEEF;
    @(posedge clk); #1;
    pre_en = 0;
    mm[5] = 32'hDEADBEEF;
    ra = 5;
    lb = 0;
    while (lb != 2 && n < 10) begin cycle(0, 1); n++; end
    checks++; if (n != 2) begin errors++; $display("FAIL read_beat_cycle got %0d exp 2", n); end
    checks++; if (rd_valid_o !== 1'b1 || rd_data_o !== 32'hDEADBEEF) begin errors++; $display("FAIL read_latency got v=%b d=%h exp v=1 d=deadbeef", rd_valid_o, rd_data_o); end
    cycle(0, 0);
    checks++; if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL read_valid_pulse got %b exp 0", rd_valid_o); end
  endtask

  task automatic test_burst_cap();
    int k, e;
    do_reset();
    wa = 10'd200; ra = 10'd0; wd = 32'h1000;
    for (int c = 0; c < 33; c++) begin
      cycle(1, 1);
      if (c > 0) begin
        k = c - 1;
        e = ((k / MB) % 2 == 0) ? 1 : 2;
        checks++; if (lb != e) begin errors++; $display("FAIL burst_pattern beat %0d got %0d exp %0d", k, lb, e); end
      end
    end
  endtask

  task automatic test_no_contention();
    int drops = 0;
    do_reset();
    wa = 10'd300; wd = 32'h2000;
    cycle(1, 1);
    checks++; if ({wr_gnt_o, rd_gnt_o} !== 2'b10) begin errors++; $display("FAIL tie_first got %b%b exp 10", wr_gnt_o, rd_gnt_o); end
    for (int i = 0; i < 40; i++) begin
      cycle(1, 0);
      if (wr_gnt_o !== 1'b1) drops++;
    end
    checks++; if (drops != 0) begin errors++; $display("FAIL solo_grant_drops got %0d exp 0", drops); end
    cycle(0, 0);
  endtask

  task automatic test_random();
    bit w, r, pw = 0, pr = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (!pw) begin wa = AW'($urandom_range(0, 15)); wd = $urandom; end
      if (!pr) ra = AW'($urandom_range(0, 15));
      w = ($urandom % 4) != 0;
      r = ($urandom % 3) != 0;
      cycle(w, r);
      pw = w && lb != 1;
      pr = r && lb != 2;
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    ra = 10'd100;
    repeat (3) cycle(0, 1);
    rd_req_i = 1;
    #2 reset_i = 1;
    #1;
    checks++; if ({wr_gnt_o, rd_gnt_o, ram_rden_o, rd_valid_o} !== 4'b0) begin errors++; $display("FAIL async_reset got %b exp 0000", {wr_gnt_o, rd_gnt_o, ram_rden_o, rd_valid_o}); end
`ifdef RAM_ARB_STATS_EN
    checks++; if (wr_wait_cnt_o !== 16'd0 || rd_wait_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_wait_cnt got %0d/%0d exp 0/0", wr_wait_cnt_o, rd_wait_cnt_o); end
`endif
    @(posedge clk); #1;
    checks++; if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL inflight_valid got %b exp 0", rd_valid_o); end
    rd_req_i = 0; reset_i = 0;
    model_reset();
    wa = 10'd400; wd = 32'h3000;
    cycle(1, 0);
    repeat (3) cycle(1, 1);
`ifdef RAM_ARB_STATS_EN
    checks++; if (rd_wait_cnt_o !== 16'd3 || wr_wait_cnt_o !== 16'd1) begin errors++; $display("FAIL wait_cnt_seq got %0d/%0d exp 1/3", wr_wait_cnt_o, rd_wait_cnt_o); end
`endif
    cycle(1, 0);
    cycle(0, 0);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_writer_alone();
    test_read_latency();
    test_burst_cap();
    test_no_contention();
    test_random();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout after 200000 time units");
    $fatal(1);
  end
endmodule
